conv3x3_stream_engine: RTL and testbench

- Parametrised successor to the fixed 3-channel convolution core; one instance per super-resolution conv layer.
- Accepts one K×K×IN_CH pixel window per valid/ready handshake.
- Computes all OUT_CH output-channel results with a single time-shared MAC, using weights and biases held in internal RAM loaded via a config port.
- Streams one saturated, rounded fixed-point result per output channel to the next layer.

---
 rtl/conv_pkg.sv | 37 +++
 rtl/conv3x3_stream_engine_if.sv | 31 +++
 rtl/conv_wgt_ram.sv | 20 ++
 rtl/conv3x3_stream_engine.sv | 156 +++++++++++++++
 tb/tb_conv3x3_stream_engine.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// Shared types, default sizing and the output round/saturate helper for the
// 3x3 streaming convolution engine.
package conv_pkg;

  typedef enum logic [1:0] {IDLE, MAC, BIAS, OUT} conv_state_t;

  localparam int DATA_W_D = 8;
  localparam int WGT_W_D  = 16;
  localparam int BIAS_W_D = 32;
  localparam int ACC_W_D  = 48;
  localparam int OUT_W_D  = 16;
  localparam int FRAC_W_D = 8;
  localparam int K_D      = 3;
  localparam int IN_CH_D  = 3;
  localparam int OUT_CH_D = 64;

  localparam int RS_ACC_W  = ACC_W_D;
  localparam int RS_OUT_W  = OUT_W_D;
  localparam int RS_FRAC_W = FRAC_W_D;

  localparam logic signed [RS_ACC_W:0] SAT_MAX = (RS_ACC_W+1)'((1 <<< (RS_OUT_W-1)) - 1);
  localparam logic signed [RS_ACC_W:0] SAT_MIN = (RS_ACC_W+1)'(-(1 <<< (RS_OUT_W-1)));

  // Round half up (add half an LSB, then floor) and clamp to the output range.
  function automatic logic signed [RS_OUT_W-1:0] round_sat(input logic signed [RS_ACC_W-1:0] acc);
    logic signed [RS_ACC_W:0] half;
    logic signed [RS_ACC_W:0] rnd;
    half = '0;
    half[RS_FRAC_W-1] = 1'b1;
    rnd = {acc[RS_ACC_W-1], acc} + half;
    rnd = rnd >>> RS_FRAC_W;
    if (rnd > SAT_MAX)      round_sat = SAT_MAX[RS_OUT_W-1:0];
    else if (rnd < SAT_MIN) round_sat = SAT_MIN[RS_OUT_W-1:0];
    else                    round_sat = rnd[RS_OUT_W-1:0];
  endfunction

endpackage

// File: rtl/conv3x3_stream_engine_if.sv
// Window-in / result-out streaming handshakes of the convolution engine.
interface conv3x3_stream_engine_if
  import conv_pkg::*;
#(
  parameter int DATA_W = DATA_W_D,
  parameter int K      = K_D,
  parameter int IN_CH  = IN_CH_D,
  parameter int OUT_W  = OUT_W_D,
  parameter int OUT_CH = OUT_CH_D
);
  localparam int CH_W = $clog2(OUT_CH);

  logic                          win_valid;
  logic                          win_ready;
  logic [IN_CH*K*K*DATA_W-1:0]   win_data;
  logic                          out_valid;
  logic                          out_ready;
  logic signed [OUT_W-1:0]       out_data;
  logic [CH_W-1:0]               out_ch;
  logic                          out_last;

  modport slave (
    input  win_valid, win_data, out_ready,
    output win_ready, out_valid, out_data, out_ch, out_last
  );

  modport master (
    output win_valid, win_data, out_ready,
    input  win_ready, out_valid, out_data, out_ch, out_last
  );
endinterface

// File: rtl/conv_wgt_ram.sv
// Generic single-write, synchronous single-read RAM used for weights and biases.
module conv_wgt_ram #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 8,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we && (32'(waddr) < DEPTH)) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/conv3x3_stream_engine.sv
// K x K x IN_CH window convolution, one time-shared MAC over OUT_CH channels.
// Optional fused ReLU on the output when CONV3X3_RELU_EN is defined.
module conv3x3_stream_engine
  import conv_pkg::*;
#(
  parameter  int DATA_W = DATA_W_D,
  parameter  int WGT_W  = WGT_W_D,
  parameter  int BIAS_W = BIAS_W_D,
  parameter  int ACC_W  = ACC_W_D,
  parameter  int OUT_W  = OUT_W_D,
  parameter  int FRAC_W = FRAC_W_D,
  parameter  int K      = K_D,
  parameter  int IN_CH  = IN_CH_D,
  parameter  int OUT_CH = OUT_CH_D,
  localparam int TAPS   = IN_CH*K*K,
  localparam int WDEPTH = OUT_CH*TAPS,
  localparam int WA_W   = $clog2(WDEPTH),
  localparam int CH_W   = $clog2(OUT_CH),
  localparam int T_W    = $clog2(TAPS+1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wgt_we,
  input  logic [WA_W-1:0]        wgt_addr,
  input  logic [WGT_W-1:0]       wgt_wdata,
  input  logic                   bias_we,
  input  logic [CH_W-1:0]        bias_addr,
  input  logic [BIAS_W-1:0]      bias_wdata,
  conv3x3_stream_engine_if.slave strm,
  output logic                   busy
);
  // state | meaning
  // IDLE  | waiting for a window, win_ready high
  // MAC   | prime cycle then one tap per cycle into acc
  // BIAS  | add bias of the current channel
  // OUT   | present rounded/saturated result until accepted
  localparam int PROD_W = DATA_W + WGT_W + 1;

  if (ACC_W < DATA_W + WGT_W + $clog2(TAPS) + 2) begin : g_acc_too_narrow
    $error("ACC_W too narrow for worst-case accumulation");
  end
  if (ACC_W != RS_ACC_W || OUT_W != RS_OUT_W || FRAC_W != RS_FRAC_W) begin : g_rs_mismatch
    $error("round_sat widths in conv_pkg do not match this instance");
  end

  conv_state_t                state;
  logic [CH_W-1:0]            oc;
  logic [T_W-1:0]             tap;
  logic [T_W-1:0]             tap_m1;
  logic [TAPS*DATA_W-1:0]     win_q;
  logic signed [ACC_W-1:0]    acc;
  logic [WA_W-1:0]            wgt_raddr;
  logic [WGT_W-1:0]           wgt_rdata;
  logic [BIAS_W-1:0]          bias_rdata;
  logic [DATA_W-1:0]          pix;
  logic signed [PROD_W-1:0]   prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    bias_ext;
  logic signed [OUT_W-1:0]    sat_val;
  logic signed [OUT_W-1:0]    result;

  conv_wgt_ram #(.DEPTH(WDEPTH), .WIDTH(WGT_W)) u_wgt_ram (
    .clk   (clk),
    .we    (wgt_we && !busy),
    .waddr (wgt_addr),
    .wdata (wgt_wdata),
    .raddr (wgt_raddr),
    .rdata (wgt_rdata)
  );

  conv_wgt_ram #(.DEPTH(OUT_CH), .WIDTH(BIAS_W)) u_bias_ram (
    .clk   (clk),
    .we    (bias_we && !busy),
    .waddr (bias_addr),
    .wdata (bias_wdata),
    .raddr (oc),
    .rdata (bias_rdata)
  );

  // Weight for tap t is fetched while tap==t and consumed while tap==t+1.
  assign wgt_raddr = WA_W'(oc) * WA_W'(TAPS) + WA_W'(tap);
  assign tap_m1    = tap - 1'b1;
  assign pix       = win_q[tap_m1*DATA_W +: DATA_W];
  assign prod      = $signed({1'b0, pix}) * $signed(wgt_rdata);
  assign prod_ext  = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  assign bias_ext  = {{(ACC_W-BIAS_W){bias_rdata[BIAS_W-1]}}, bias_rdata};
  assign sat_val   = round_sat(acc);

`ifdef CONV3X3_RELU_EN
  assign result = sat_val[OUT_W-1] ? '0 : sat_val;
`else
  assign result = sat_val;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      strm.win_ready <= 1'b1;
      strm.out_valid <= 1'b0;
      strm.out_data  <= '0;
      strm.out_ch    <= '0;
      strm.out_last  <= 1'b0;
      busy           <= 1'b0;
      oc             <= '0;
      tap            <= '0;
      acc            <= '0;
      win_q          <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (strm.win_valid && strm.win_ready) begin
            win_q          <= strm.win_data;
            oc             <= '0;
            tap            <= '0;
            acc            <= '0;
            strm.win_ready <= 1'b0;
            busy           <= 1'b1;
            state          <= MAC;
          end
        end
        MAC: begin
          if (tap != '0) acc <= acc + prod_ext;
          if (tap == T_W'(TAPS)) begin
            tap   <= '0;
            state <= BIAS;
          end else begin
            tap <= tap + 1'b1;
          end
        end
        BIAS: begin
          acc   <= acc + bias_ext;
          state <= OUT;
        end
        OUT: begin
          if (!strm.out_valid) begin
            strm.out_valid <= 1'b1;
            strm.out_data  <= result;
            strm.out_ch    <= oc;
            strm.out_last  <= (oc == CH_W'(OUT_CH-1));
          end else if (strm.out_ready) begin
            strm.out_valid <= 1'b0;
            if (strm.out_last) begin
              strm.win_ready <= 1'b1;
              busy           <= 1'b0;
              state          <= IDLE;
            end else begin
              oc    <= oc + 1'b1;
              acc   <= '0;
              state <= MAC;
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_conv3x3_stream_engine.sv
// Directed + randomized bench for conv3x3_stream_engine against an arithmetic reference model.
`timescale 1ns/1ps
module tb_conv3x3_stream_engine;
  import conv_pkg::*;

  localparam int TAPS = IN_CH_D*K_D*K_D;
  localparam int NW   = OUT_CH_D*TAPS;
  localparam int WA_W = $clog2(NW);
  localparam int CH_W = $clog2(OUT_CH_D);
  localparam int LAT  = TAPS + 3;

  typedef logic [DATA_W_D-1:0] pix_arr_t [TAPS];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wgt_we = 1'b0;
  logic [WA_W-1:0] wgt_addr = '0;
  logic [WGT_W_D-1:0] wgt_wdata = '0;
  logic bias_we = 1'b0;
  logic [CH_W-1:0] bias_addr = '0;
  logic [BIAS_W_D-1:0] bias_wdata = '0;
  logic busy;

  conv3x3_stream_engine_if s_if ();

  conv3x3_stream_engine dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wgt_we     (wgt_we),
    .wgt_addr   (wgt_addr),
    .wgt_wdata  (wgt_wdata),
    .bias_we    (bias_we),
    .bias_addr  (bias_addr),
    .bias_wdata (bias_wdata),
    .strm       (s_if),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  shortint w_m [NW];
  int b_m [OUT_CH_D];
  pix_arr_t px_a, px_b;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: dot product over the window, plus bias, scaled back by 2^FRAC_W
  // with round-half-up, clamped to the signed output range.
  function automatic longint model(input int oc, input pix_arr_t px);
    longint acc;
    longint q;
    acc = 0;
    foreach (px[t]) acc += longint'(px[t]) * longint'(w_m[oc*TAPS + t]);
    acc += longint'(b_m[oc]);
    q = longint'($floor(real'(acc) / real'(1 << FRAC_W_D) + 0.5));
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
`ifdef CONV3X3_RELU_EN
    if (q < 0) q = 0;
`endif
    return q;
  endfunction

  task automatic wr_cfg(input bit we_w, input int a, input int v, input bit we_b, input int ba, input int bv);
    wgt_we = we_w; wgt_addr = WA_W'(a); wgt_wdata = WGT_W_D'(v);
    bias_we = we_b; bias_addr = CH_W'(ba); bias_wdata = BIAS_W_D'(bv);
    tick();
    wgt_we = 1'b0; bias_we = 1'b0;
    if (we_w && a < NW) w_m[a] = shortint'(v);
    if (we_b) b_m[ba] = bv;
  endtask

  // mode: 0 zero, 1 max positive, 2 max negative, 3 random
  task automatic fill_all(input int mode);
    int v, bv;
    for (int a = 0; a < NW; a++) begin
      v  = (mode == 0) ? 0 : (mode == 1) ? 32'h7FFF : (mode == 2) ? 32'h8000
         : int'($urandom_range(0, 4000)) - 2000;
      bv = (mode == 3) ? int'($urandom_range(0, 131072)) - 65536 : 0;
      wr_cfg(1'b1, a, v, a < OUT_CH_D, a % OUT_CH_D, bv);
    end
  endtask

  task automatic drive_win(input pix_arr_t px);
    foreach (px[t]) s_if.win_data[t*DATA_W_D +: DATA_W_D] = px[t];
  endtask

  task automatic run_window(input pix_arr_t px, input int stall_ch, input bit rnd_rdy,
                            input bit guard_wr, input bit chain, input pix_arr_t nxt,
                            input bit expect_b2b);
    int n, ref_c;
    logic rdy;
    longint e;
    drive_win(px);
    s_if.win_valid = 1'b1;
    n = 0;
    while (!s_if.win_ready && n < 5000) begin tick(); n++; end
    if (expect_b2b) chk("b2b_accept_gap", n, 0);
    if (n >= 5000) begin
      chk("accept_timeout", 0, 1);
      s_if.win_valid = 1'b0;
      return;
    end
    tick();
    ref_c = cyc;
    if (chain) drive_win(nxt);
    else s_if.win_valid = 1'b0;
    chk("busy_after_accept", busy, 1);
    chk("win_ready_after_accept", s_if.win_ready, 0);
    if (guard_wr) begin
      wgt_we = 1'b1; wgt_addr = WA_W'(4); wgt_wdata = 16'h1234;
      tick();
      wgt_we = 1'b0;
    end
    for (int oc = 0; oc < OUT_CH_D; oc++) begin
      while (!s_if.out_valid && (cyc - ref_c) < 200) tick();
      chk($sformatf("latency_oc%0d", oc), cyc - ref_c, LAT);
      if (!s_if.out_valid) return;
      e = model(oc, px);
      chk("out_ch", s_if.out_ch, oc);
      chk($sformatf("out_data_oc%0d", oc), s_if.out_data, e);
      chk("out_last", s_if.out_last, oc == OUT_CH_D - 1);
      for (int k = 0; k < 64; k++) begin
        if (oc == stall_ch && k < 5) rdy = 1'b0;
        else if (rnd_rdy && k < 63) rdy = 1'($urandom_range(0, 1));
        else rdy = 1'b1;
        s_if.out_ready = rdy;
        tick();
        if (rdy) break;
        chk("hold_valid", s_if.out_valid, 1);
        chk("hold_ch", s_if.out_ch, oc);
        chk("hold_data", s_if.out_data, e);
        chk("hold_win_ready", s_if.win_ready, 0);
      end
      ref_c = cyc;
    end
    chk("win_ready_after_last", s_if.win_ready, 1);
    chk("busy_after_last", busy, 0);
    chk("out_valid_after_last", s_if.out_valid, 0);
  endtask

  initial begin
    s_if.win_valid = 1'b0;
    s_if.win_data  = '0;
    s_if.out_ready = 1'b1;
    repeat (3) tick();
    chk("rst_win_ready", s_if.win_ready, 1);
    chk("rst_out_valid", s_if.out_valid, 0);
    chk("rst_out_data", s_if.out_data, 0);
    chk("rst_out_ch", s_if.out_ch, 0);
    chk("rst_out_last", s_if.out_last, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();

    // Identity tap (0,1,1) of channel 0, with a 5-cycle stall on channel 10
    fill_all(0);
    wr_cfg(1'b1, 4, 256, 1'b0, 0, 0);
    foreach (px_a[t]) px_a[t] = DATA_W_D'($urandom_range(0, 255));
    px_a[4] = 8'd200;
    chk("model_identity", model(0, px_a), 200);
    run_window(px_a, 10, 1'b0, 1'b0, 1'b0, px_a, 1'b0);

    // Writes while busy must not land
    run_window(px_a, -1, 1'b0, 1'b1, 1'b0, px_a, 1'b0);
    run_window(px_a, -1, 1'b0, 1'b0, 1'b0, px_a, 1'b0);

    // Asynchronous reset in the middle of MAC
    drive_win(px_a);
    s_if.win_valid = 1'b1;
    tick();
    s_if.win_valid = 1'b0;
    chk("pre_rst_busy", busy, 1);
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", s_if.out_valid, 0);
    chk("midrst_win_ready", s_if.win_ready, 1);
    chk("midrst_busy", busy, 0);
    tick();
    rst_n = 1'b1;
    tick();
    run_window(px_a, -1, 1'b0, 1'b0, 1'b0, px_a, 1'b0);

    // Negative product rounding, with and without bias
    wr_cfg(1'b1, 4, -384, 1'b0, 0, 0);
    px_a[4] = 8'd3;
    run_window(px_a, -1, 1'b0, 1'b0, 1'b0, px_a, 1'b0);
    wr_cfg(1'b0, 0, 0, 1'b1, 0, 128);
    run_window(px_a, -1, 1'b0, 1'b0, 1'b0, px_a, 1'b0);
    wr_cfg(1'b1, NW + 5, 16'h7777, 1'b1, 0, 129);
    run_window(px_a, -1, 1'b0, 1'b0, 1'b0, px_a, 1'b0);

    // Saturation both ways
    foreach (px_a[t]) px_a[t] = 8'd255;
    fill_all(1);
    run_window(px_a, -1, 1'b0, 1'b0, 1'b0, px_a, 1'b0);
    fill_all(2);
    run_window(px_a, -1, 1'b0, 1'b0, 1'b0, px_a, 1'b0);

    // Random weights/biases/pixels, back-to-back windows, random backpressure
    fill_all(3);
    foreach (px_a[t]) px_a[t] = DATA_W_D'($urandom_range(0, 255));
    foreach (px_b[t]) px_b[t] = DATA_W_D'($urandom_range(0, 255));
    run_window(px_a, 20, 1'b1, 1'b0, 1'b1, px_b, 1'b0);
    run_window(px_b, -1, 1'b1, 1'b0, 1'b0, px_b, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
